port_uart_tx: RTL and testbench
===============================

# port_uart_tx

Serial debug sink for one 8-bit output port of the `top` processor (e.g. `portCwire`). It watches the port every cycle and queues each new value in a small FIFO. Queued values are transmitted as standard 8N1 UART frames on a single `tx` line. The block sits directly downstream of `top`, so port writes from a running program are observable off-chip without stalling the core.

## Interface
Parameters:
- `WIDTH`, 8: port width and number of data bits per frame.
- `CLKS_PER_BIT`, 4: clock cycles per UART bit. Must be ≥ 2. Use 4 in simulation and 868 for 115200 baud at 100 MHz.
- `FIFO_DEPTH`, 4: number of queued port values. Must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `port_in`, input, `WIDTH`: processor output port being monitored.
- `tx`, output, 1: UART serial line. Registered; idles high.
- `busy`, output, 1: high while a frame is in progress, i.e. state ≠ IDLE.
- `fifo_count`, output, `$clog2(FIFO_DEPTH)+1`: number of queued entries.
- `overflow`, output, 1: sticky flag, set when a change is dropped because the FIFO is full.

## Operation
Change detector:
- `prev` register samples `port_in` every cycle. It resets to 0.
- A push is requested on any edge where `port_in != prev`.
- After reset, a nonzero `port_in` therefore produces one push.

FIFO:
- Circular buffer with read/write pointers and a count.
- A push is accepted if `fifo_count < FIFO_DEPTH`, or if a pop happens on the same edge.
- If a push is rejected, the value is discarded and `overflow` is set to 1. `overflow` is cleared only by `rst`.
- On a simultaneous push and pop, `fifo_count` is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

TX state machine (IDLE, START, DATA, STOP):
- IDLE: `tx`=1.
  - If `fifo_count>0`, pop the head entry into the shift register, clear the bit timer, and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: `tx` = shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first.
  - After each bit: shift right and increment the index.
  - After `WIDTH` bits, go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
  - At the end, if `fifo_count>0`, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- Frame length is exactly `(WIDTH+2)*CLKS_PER_BIT` cycles.

Reset, on any edge with `rst`=1, including mid-frame:
- `tx`=1, `busy`=0, state=IDLE.
- FIFO emptied: pointers=0, `fifo_count`=0.
- `overflow`=0, `prev`=0, shift register and timers cleared.
- An interrupted frame is not resumed.

## Timing
- All outputs are registered.
- Latency: `port_in` change sampled at edge k → entry visible in `fifo_count` after edge k → popped at edge k+1 → `tx` low from edge k+1.
- `busy` rises at the same edge `tx` first goes low. It falls at the edge that enters IDLE.
- Bit boundaries are exactly `CLKS_PER_BIT` cycles apart. No jitter is allowed.
- A pop and the STOP→START transition occur on the same edge.
- Back-to-back frames are contiguous. `tx` stays high for exactly `CLKS_PER_BIT` cycles of stop bit between frames.
- `port_in` glitches lasting one cycle are captured; the detector has no filtering.

## Test plan
`WIDTH`=8, `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4, 10 ns clock.

1. Reset check: hold `rst`=1 for 2 cycles with `port_in`=0.
   - Required: `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0, and no activity for 20 cycles after release.
2. Single frame: `port_in` 0x00→0xED, then held.
   - Required: `tx` low 4 cycles, then bits 1,0,1,1,0,1,1,1 (4 cycles each), then high.
   - Frame lasts 40 cycles. `busy` is high for exactly 40 cycles.
   - No second frame follows while `port_in` stays constant.
3. Burst/overflow: `port_in` = 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles, then held.
   - Required: `fifo_count` peaks at 4 and `overflow`=1.
   - Exactly five frames (0x01–0x05) are sent, contiguous, 200 cycles total. 0x06 is never sent.
4. Revisit value: 0x00→0x55, wait 60 cycles, →0x00.
   - Required: two frames, 0x55 then 0x00. The 0x00 frame is 4 cycles low (start), 32 low, 4 high (stop).
5. Reset mid-frame: send 0xED; assert `rst` for 1 cycle 10 cycles into the frame, with `port_in` still 0xED.
   - Required: `tx`=1 and `fifo_count`=0 after the reset edge.
   - Then a fresh, complete 0xED frame, because `prev` was reset to 0.
6. Push on pop: fill FIFO to 4 during a frame, then change `port_in` on the STOP-end edge.
   - Required: the push is accepted, `fifo_count` stays 4, `overflow` stays 0.

Source files
------------

// File: rtl/port_uart_tx.sv
// port_uart_tx: queues every change on a processor output port and sends it as 8N1 UART frames.
//   clk, rst         : clock, synchronous active-high reset
//   port_in          : monitored processor output port
//   tx               : registered UART line, idles high
//   busy             : high while a frame is in progress
//   fifo_count       : number of queued port values
//   overflow         : sticky, set when a change is dropped on a full FIFO
module port_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              port_in,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(WIDTH);
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

   stateT            state, stateNext;
   logic [TW-1:0]    timer, timerNext;
   logic [BW-1:0]    bitIdx, bitIdxNext;
   logic [WIDTH-1:0] shift, shiftNext;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wrPtr, rdPtr;
   logic             txNext, push, pushOk, pop, bitEnd;

   assign push   = port_in != prev;
   // a full FIFO still accepts a push when the head leaves on the same edge
   assign pushOk = push && (fifo_count != FULL || pop);
   assign bitEnd = timer == LAST_TICK;

   always_comb begin
      stateNext  = state;
      timerNext  = timer + 1'b1;
      bitIdxNext = bitIdx;
      shiftNext  = shift;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            timerNext = '0;
            if (fifo_count != '0) begin
               pop       = 1'b1;
               shiftNext = mem[rdPtr];
               stateNext = START;
            end
         end
         START: if (bitEnd) begin
            timerNext  = '0;
            bitIdxNext = '0;
            stateNext  = DATA;
         end
         DATA: if (bitEnd) begin
            timerNext  = '0;
            shiftNext  = shift >> 1;
            bitIdxNext = bitIdx + 1'b1;
            if (bitIdx == LAST_BIT) stateNext = STOP;
         end
         default: if (bitEnd) begin
            timerNext = '0;
            // chain straight into the next frame so frames stay contiguous
            if (fifo_count != '0) begin
               pop       = 1'b1;
               shiftNext = mem[rdPtr];
               stateNext = START;
            end else stateNext = IDLE;
         end
      endcase
      // tx is registered from the next-state values so it changes on the transition edge
      txNext = stateNext == START ? 1'b0 : stateNext == DATA ? shiftNext[0] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         bitIdx     <= '0;
         shift      <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         prev       <= '0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         state  <= stateNext;
         timer  <= timerNext;
         bitIdx <= bitIdxNext;
         shift  <= shiftNext;
         tx     <= txNext;
         busy   <= stateNext != IDLE;
         prev   <= port_in;
         if (pushOk) wrPtr <= wrPtr + 1'b1;
         if (pop) rdPtr <= rdPtr + 1'b1;
         if (pushOk && !pop) fifo_count <= fifo_count + 1'b1;
         else if (!pushOk && pop) fifo_count <= fifo_count - 1'b1;
         if (push && !pushOk) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (pushOk) mem[wrPtr] <= port_in;
   end
endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: directed self-checking bench for port_uart_tx (8 bits, 4 clocks per bit, depth 4).
module tb_port_uart_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] port_in = 8'h00;
   logic       tx, busy, overflow;
   logic [2:0] fifo_count;
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;

   logic [7:0] fd [6];
   bit         fok [6];
   int         fs [6], fb [6], fl [6];

   port_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .port_in(port_in), .tx(tx), .busy(busy),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Captures one 40-cycle frame sampled at negedges; ok reports framing and timeout, no comparisons here.
   task automatic get_frame(output logic [7:0] d, output bit ok, output int start, output int busyCnt, output int lowCnt);
      logic s [40];
      int   w = 0;
      ok = 1; d = '0; start = -1; busyCnt = 0; lowCnt = 0;
      while (tx !== 1'b0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (tx !== 1'b0) begin
         ok = 0;
         return;
      end
      start = cyc;
      for (int i = 0; i < 40; i++) begin
         s[i] = tx;
         busyCnt += int'(busy === 1'b1);
         lowCnt += int'(tx === 1'b0);
         @(negedge clk);
      end
      for (int b = 0; b < 10; b++)
         for (int j = 1; j < 4; j++)
            if (s[b*4+j] !== s[b*4]) ok = 0;
      if (s[0] !== 1'b0 || s[36] !== 1'b1) ok = 0;
      for (int b = 0; b < 8; b++) d[b] = s[4+b*4];
   endtask

   task automatic test_reset;
      bit act = 0;
      rst = 1; port_in = 8'h00;
      repeat (2) @(negedge clk);
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", fifo_count); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
      rst = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) act = 1;
      end
      tests++; if (act) begin fails++; $display("FAIL reset_quiet got activity want none"); end
   endtask

   task automatic test_single;
      int c0 = cyc;
      bit act = 0;
      port_in = 8'hED;
      @(negedge clk);
      tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_queued got %0d want 1", fifo_count); end
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_not_yet got %b want 1", tx); end
      get_frame(fd[0], fok[0], fs[0], fb[0], fl[0]);
      tests++; if (fok[0] !== 1'b1) begin fails++; $display("FAIL single_framing got %b want 1", fok[0]); end
      tests++; if (fd[0] !== 8'hED) begin fails++; $display("FAIL single_data got %h want ed", fd[0]); end
      tests++; if (fs[0] - c0 !== 2) begin fails++; $display("FAIL single_latency got %0d want 2", fs[0] - c0); end
      tests++; if (fb[0] !== 40) begin fails++; $display("FAIL single_busy_len got %0d want 40", fb[0]); end
      tests++; if (fl[0] !== 12) begin fails++; $display("FAIL single_low_cycles got %0d want 12", fl[0]); end
      tests++; if (busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL single_end got busy=%b tx=%b want 0 1", busy, tx); end
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) act = 1;
      end
      tests++; if (act) begin fails++; $display("FAIL single_no_repeat got activity want none"); end
   endtask

   task automatic test_burst;
      int c0 = cyc;
      int peak = 0;
      bit act = 0;
      fork
         begin
            for (int v = 1; v <= 6; v++) begin
               port_in = 8'(v);
               @(negedge clk);
               if (int'(fifo_count) > peak) peak = int'(fifo_count);
            end
         end
         begin
            for (int f = 0; f < 5; f++) get_frame(fd[f], fok[f], fs[f], fb[f], fl[f]);
         end
      join
      tests++; if (peak !== 4) begin fails++; $display("FAIL burst_peak got %0d want 4", peak); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL burst_overflow got %b want 1", overflow); end
      tests++; if (fs[0] - c0 !== 2) begin fails++; $display("FAIL burst_latency got %0d want 2", fs[0] - c0); end
      for (int f = 0; f < 5; f++) begin
         tests++; if (fok[f] !== 1'b1 || fd[f] !== 8'(f + 1)) begin fails++; $display("FAIL burst_frame%0d got %h ok=%b want %h", f, fd[f], fok[f], 8'(f + 1)); end
         tests++; if (fs[f] - fs[0] !== 40 * f) begin fails++; $display("FAIL burst_spacing%0d got %0d want %0d", f, fs[f] - fs[0], 40 * f); end
      end
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) act = 1;
      end
      tests++; if (act) begin fails++; $display("FAIL burst_no_sixth got activity want none"); end
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL burst_drained got %0d want 0", fifo_count); end
   endtask

   task automatic test_revisit;
      int c0;
      rst = 1; port_in = 8'h00;
      @(negedge clk);
      rst = 0;
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL revisit_ovf_cleared got %b want 0", overflow); end
      c0 = cyc;
      port_in = 8'h55;
      fork
         begin
            repeat (60) @(negedge clk);
            port_in = 8'h00;
         end
         begin
            for (int f = 0; f < 2; f++) get_frame(fd[f], fok[f], fs[f], fb[f], fl[f]);
         end
      join
      tests++; if (fok[0] !== 1'b1 || fd[0] !== 8'h55) begin fails++; $display("FAIL revisit_first got %h ok=%b want 55", fd[0], fok[0]); end
      tests++; if (fok[1] !== 1'b1 || fd[1] !== 8'h00) begin fails++; $display("FAIL revisit_second got %h ok=%b want 00", fd[1], fok[1]); end
      tests++; if (fl[1] !== 36) begin fails++; $display("FAIL revisit_zero_low got %0d want 36", fl[1]); end
      tests++; if (fs[0] - c0 !== 2 || fs[1] - fs[0] !== 60) begin fails++; $display("FAIL revisit_timing got %0d,%0d want 2,60", fs[0] - c0, fs[1] - fs[0]); end
   endtask

   task automatic test_midreset;
      int c0 = cyc;
      int r;
      port_in = 8'hED;
      while (cyc != c0 + 12) @(negedge clk);
      tests++; if (tx !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL midreset_in_frame got tx=%b busy=%b want 0 1", tx, busy); end
      rst = 1;
      @(negedge clk);
      r = cyc;
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midreset_tx got %b want 1", tx); end
      tests++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_state got count=%0d busy=%b want 0 0", fifo_count, busy); end
      rst = 0;
      get_frame(fd[0], fok[0], fs[0], fb[0], fl[0]);
      tests++; if (fok[0] !== 1'b1 || fd[0] !== 8'hED) begin fails++; $display("FAIL midreset_fresh got %h ok=%b want ed", fd[0], fok[0]); end
      tests++; if (fs[0] - r !== 2) begin fails++; $display("FAIL midreset_latency got %0d want 2", fs[0] - r); end
   endtask

   task automatic test_push_on_pop;
      int c0 = cyc;
      fork
         begin
            port_in = 8'h11; @(negedge clk);
            port_in = 8'h22; @(negedge clk);
            port_in = 8'h33; @(negedge clk);
            port_in = 8'h44; @(negedge clk);
            port_in = 8'h55;
            while (cyc != c0 + 41) @(negedge clk);
            tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL pop_full_before got %0d want 4", fifo_count); end
            port_in = 8'h66;
            @(negedge clk);
            tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL pop_count_after got %0d want 4", fifo_count); end
            tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL pop_overflow got %b want 0", overflow); end
         end
         begin
            for (int f = 0; f < 6; f++) get_frame(fd[f], fok[f], fs[f], fb[f], fl[f]);
         end
      join
      for (int f = 0; f < 6; f++) begin
         tests++; if (fok[f] !== 1'b1 || fd[f] !== 8'((f + 1) * 17)) begin fails++; $display("FAIL pop_frame%0d got %h ok=%b want %h", f, fd[f], fok[f], 8'((f + 1) * 17)); end
      end
      tests++; if (fs[5] - fs[0] !== 200) begin fails++; $display("FAIL pop_contiguous got %0d want 200", fs[5] - fs[0]); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_burst;
      test_revisit;
      test_midreset;
      test_push_on_pop;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
